pipe_run_monitor: RTL

Synthesizable run-control and completion monitor for the pipelined core. It pulses the core reset, latches a program's exit address, and watches the fetch PC. After the PC reaches the exit address, it drains the pipeline for a stall-aware number of cycles, then reports pass or timeout together with cycle and stall counts. It generalises the fixed "exit + 4×4, 100-cycle" rule to arbitrary pipeline depth, timeout, reset length and counter width, and sits beside `pipelined`, driving its `rstn`.

---
 rtl/pipe_mon_pkg.sv | 16 +
 rtl/sat_counter.sv | 34 +++
 rtl/pipe_run_monitor.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pipe_mon_pkg.sv
// Shared types and default parameters for the pipelined-core run monitor.
package pipe_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_TIMEOUT
    } mon_state_t;

    localparam int PIPE_STAGES_DEF = 5;
    localparam int TIMEOUT_DEF     = 100;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_run_monitor.sv
// Run-control monitor: pulses the core reset, watches the fetch PC for the exit
// address, drains the pipeline (stall-aware) and reports done/timeout with counts.
module pipe_run_monitor
    import pipe_mon_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int PIPE_STAGES = PIPE_STAGES_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int RST_CYCLES  = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] exit_addr,
    input  logic                  ack,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  stall,
    output logic                  core_rstn,
    output logic                  busy,
    output logic                  done,
    output logic                  timed_out,
    output logic [CNT_WIDTH-1:0]  cycles,
    output logic [CNT_WIDTH-1:0]  stalls
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int DW = $clog2(PIPE_STAGES + 1);

    localparam logic [RW-1:0]        RST_LOAD   = RW'(RST_CYCLES - 1);
    localparam logic [DW-1:0]        DRAIN_LOAD = DW'(PIPE_STAGES - 1);
    localparam logic [CNT_WIDTH-1:0] TMO_LAST   = CNT_WIDTH'(TIMEOUT - 1);

    mon_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] exit_q, exit_d;
    logic [RW-1:0]         rst_cnt_q, rst_cnt_d;
    logic [DW-1:0]         drain_cnt_q, drain_cnt_d;
    logic                  core_rstn_q, busy_q, done_q, timed_out_q;

    logic                  start_accept;
    logic                  counting;
    logic [CNT_WIDTH-1:0]  cycles_cnt;
    logic [CNT_WIDTH-1:0]  stalls_cnt;

    assign start_accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                    (state_q == ST_TIMEOUT));
    assign counting     = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    always_comb begin
        state_d     = state_q;
        exit_d      = exit_q;
        rst_cnt_d   = rst_cnt_q;
        drain_cnt_d = drain_cnt_q;

        if (start_accept) begin
            state_d   = ST_RESET;
            exit_d    = exit_addr;
            rst_cnt_d = RST_LOAD;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_RESET: begin
                    if (rst_cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        rst_cnt_d = rst_cnt_q - RW'(1);
                    end
                end
                ST_RUN: begin
                    if (pc == exit_q) begin
                        if (PIPE_STAGES == 1) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d     = ST_DRAIN;
                            drain_cnt_d = DRAIN_LOAD;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Stalled cycles don't retire anything, so they don't count toward the drain.
                    if (!stall) begin
                        if (drain_cnt_q <= DW'(1)) begin
                            state_d = ST_DONE;
                        end
                        drain_cnt_d = drain_cnt_q - DW'(1);
                    end
                end
                ST_DONE, ST_TIMEOUT: begin
                    if (ack) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Completion on the last allowed cycle beats the timeout.
            if (counting && (cycles_cnt == TMO_LAST) && (state_d != ST_DONE)) begin
                state_d = ST_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            exit_q      <= '0;
            rst_cnt_q   <= '0;
            drain_cnt_q <= '0;
            core_rstn_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            exit_q      <= exit_d;
            rst_cnt_q   <= rst_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            core_rstn_q <= (state_d != ST_RESET);
            busy_q      <= (state_d == ST_RESET) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
            done_q      <= (state_d == ST_DONE);
            timed_out_q <= (state_d == ST_TIMEOUT);
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cycles (
        .clk  (clk),
        .rstn (rstn),
        .clr  (start_accept),
        .inc  (counting),
        .q    (cycles_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stalls (
        .clk  (clk),
        .rstn (rstn),
        .clr  (start_accept),
        .inc  (counting && stall),
        .q    (stalls_cnt)
    );

    assign core_rstn = core_rstn_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timed_out = timed_out_q;
    assign cycles    = cycles_cnt;
    assign stalls    = stalls_cnt;

endmodule
